imem_ctrl: RTL and testbench
============================

# imem_ctrl

Sequencer and arbiter for the single-port 32x20 instruction memory. It owns the memory's enable, read/write select, address and write-data pins and shares them between two requesters: a program loader (writes) and the fetch unit (reads). After reset only the loader is served (BOOT). Once the program is loaded, fetch is enabled and the two requesters are arbitrated round-robin (RUN).

## Interface
Parameters:
- DATA_W, 20, instruction word width
- ADDR_W, 5, word address width
- DEPTH, 32, words in memory (2**ADDR_W)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ld_valid  in  1  loader write request
- ld_ready  out  1  loader request accepted this cycle
- ld_addr  in  ADDR_W  write address
- ld_data  in  DATA_W  write data
- ld_last  in  1  marks final word of the boot program
- fe_valid  in  1  fetch read request
- fe_ready  out  1  fetch request accepted this cycle
- fe_addr  in  ADDR_W  read address
- fe_rvalid  out  1  read data valid
- fe_rdata  out  DATA_W  read data
- fe_raddr  out  ADDR_W  address of the word on fe_rdata
- load_done  out  1  high once BOOT has completed (sticky until rst)
- ld_count  out  ADDR_W+1  accepted loader writes, saturating at DEPTH
- mem_enable  out  1  memory enable
- mem_read_writenot  out  1  1 = read, 0 = write
- mem_read_address  out  ADDR_W  equals fe_addr
- mem_write_address  out  ADDR_W  equals ld_addr
- mem_in_data  out  DATA_W  equals ld_data
- mem_out_data  in  DATA_W  registered memory read data

## Operation
- State register: BOOT (reset state) or RUN.
- BOOT:
  - fe_ready = 0.
  - grant_ld = ld_valid.
  - BOOT -> RUN on an accepted write with ld_last = 1, or on the accepted write that brings ld_count to DEPTH.
- RUN:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted. The last-granted bit resets to "loader", so fetch wins the first tie in RUN.
  - The last-granted bit updates on every grant.
- Handshake:
  - ld_ready = grant_ld and fe_ready = grant_fe. Both are combinational from the valids.
  - A requester must hold valid and its payload stable until ready. A requester must not make valid depend on ready.
- Memory pins:
  - mem_enable = grant_ld | grant_fe.
  - mem_read_writenot = ~grant_ld, so it is 1 when idle.
  - Addresses and data pass through combinationally.
- Counters and flags:
  - ld_count increments on each accepted write and saturates at DEPTH.
  - load_done = (state == RUN).
- Read return:
  - fe_rvalid is registered and goes high the cycle after grant_fe.
  - fe_raddr is registered from fe_addr on grant_fe.
  - fe_rdata = mem_out_data. It is valid only while fe_rvalid = 1, because the memory holds its last value otherwise.
- Exactly one memory operation per cycle. Read and write never collide.

## Timing
- Accept to memory access: the same edge (memory samples pins on the clk edge where ready = 1).
- Read latency: 1 cycle. Accept at edge N gives fe_rvalid = 1 during cycle N+1.
- Throughput: one access per cycle. Back-to-back fetches give continuous fe_rvalid.
- While rst = 1, all grants are forced to 0: ld_ready = fe_ready = mem_enable = 0, mem_read_writenot = 1.
- Reset values: state BOOT, load_done 0, ld_count 0, fe_rvalid 0, fe_raddr 0, last-granted = loader.
- Reset mid-operation: an in-flight read is discarded, and fe_rvalid is 0 after the reset edge. The memory contents are not modified by the controller.
- Writes accepted after ld_count saturates still complete, and the count stays at DEPTH.

## Configuration
- IMEM_WRITE_LOCK_EN defined:
  - In RUN, ld_ready = 0 permanently and the memory is read-only until rst.
  - Fetch is granted whenever fe_valid = 1.
- IMEM_WRITE_LOCK_EN undefined: RUN arbitrates round-robin as described above.

## Test plan
- Boot load: rst, then 3 writes (addr 0..2, data 20'h00011/22/33, last on the third) -> ld_count = 3, load_done = 1 the cycle after the third accept, and fe_ready stays 0 throughout BOOT even with fe_valid = 1.
- Saturation: 32 writes with ld_last = 0 -> RUN entered after the 32nd accept, ld_count = 32. A 33rd write (lock off) -> count stays 32.
- Read return: in RUN, fetch addr 1 -> next cycle fe_rvalid = 1, fe_raddr = 1, fe_rdata = 20'h00022. Fetch addrs 0,1,2 back-to-back -> three consecutive valid responses in order.
- Contention (lock off): both valid every cycle -> grants alternate fe, ld, fe, ld. A write of 20'hABCDE to addr 0 followed by a fetch of addr 0 -> fe_rdata = 20'hABCDE.
- Lock (IMEM_WRITE_LOCK_EN): in RUN, ld_valid = 1 for 10 cycles -> ld_ready = 0, mem_read_writenot never 0.
- Reset mid-read: rst asserted on the cycle after fetch accept -> fe_rvalid = 0, load_done = 0, ld_count = 0, and fe_ready = 0 until a new boot load completes.

Source files
------------

// File: rtl/imem_ctrl.sv
// Sequencer/arbiter for the single-port instruction memory: boot loader first, then round-robin with fetch.
// Optional IMEM_WRITE_LOCK_EN makes memory read-only once boot completes.
module imem_ctrl #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              fe_valid,
  output logic              fe_ready,
  input  logic [ADDR_W-1:0] fe_addr,
  output logic              fe_rvalid,
  output logic [DATA_W-1:0] fe_rdata,
  output logic [ADDR_W-1:0] fe_raddr,
  output logic              load_done,
  output logic [ADDR_W:0]   ld_count,
  output logic              mem_enable,
  output logic              mem_read_writenot,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_in_data,
  input  logic [DATA_W-1:0] mem_out_data
);

  localparam logic [ADDR_W:0] LP_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    S_BOOT,
    S_RUN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_grant_ld;
  logic              w_grant_fe;
  logic              r_last_fe;
  logic [ADDR_W:0]   r_cnt;
  logic              r_rvalid;
  logic [ADDR_W-1:0] r_raddr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_BOOT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_ld  = 1'b0;
    w_grant_fe  = 1'b0;
    if (!rst) begin
      unique case (r_state)
        S_BOOT: begin
          w_grant_ld = ld_valid;
          if (ld_valid && (ld_last || r_cnt == LP_MAX - 1'b1))
            w_state_nxt = S_RUN;
        end
        S_RUN: begin
`ifdef IMEM_WRITE_LOCK_EN
          w_grant_fe = fe_valid;
`else
          // On a tie, whoever was not served last goes next
          if (ld_valid && fe_valid) begin
            w_grant_fe = ~r_last_fe;
            w_grant_ld = r_last_fe;
          end else begin
            w_grant_fe = fe_valid;
            w_grant_ld = ld_valid;
          end
`endif
        end
        default: w_state_nxt = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_fe <= 1'b0;
      r_cnt     <= '0;
      r_rvalid  <= 1'b0;
      r_raddr   <= '0;
    end else begin
      r_rvalid <= w_grant_fe;
      if (w_grant_fe)
        r_raddr <= fe_addr;
      if (w_grant_ld && r_cnt != LP_MAX)
        r_cnt <= r_cnt + 1'b1;
      if (w_grant_ld || w_grant_fe)
        r_last_fe <= w_grant_fe;
    end
  end

  assign ld_ready          = w_grant_ld;
  assign fe_ready          = w_grant_fe;
  assign mem_enable        = w_grant_ld | w_grant_fe;
  assign mem_read_writenot = ~w_grant_ld;
  assign mem_read_address  = fe_addr;
  assign mem_write_address = ld_addr;
  assign mem_in_data       = ld_data;
  assign fe_rvalid         = r_rvalid;
  assign fe_raddr          = r_raddr;
  assign fe_rdata          = mem_out_data;
  assign load_done         = (r_state == S_RUN);
  assign ld_count          = r_cnt;

endmodule

// File: tb/tb_imem_ctrl.sv
// Randomized bench for imem_ctrl with a behavioural reference model
// and a simple registered-read memory attached to the controller pins.
module tb_imem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid, ld_ready, ld_last;
  logic [4:0]  ld_addr;
  logic [19:0] ld_data;
  logic        fe_valid, fe_ready;
  logic [4:0]  fe_addr;
  logic        fe_rvalid;
  logic [19:0] fe_rdata;
  logic [4:0]  fe_raddr;
  logic        load_done;
  logic [5:0]  ld_count;
  logic        mem_enable, mem_read_writenot;
  logic [4:0]  mem_read_address, mem_write_address;
  logic [19:0] mem_in_data, mem_out_data;

  int total = 0;
  int bad   = 0;

  imem_ctrl dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .fe_valid(fe_valid), .fe_ready(fe_ready), .fe_addr(fe_addr),
    .fe_rvalid(fe_rvalid), .fe_rdata(fe_rdata), .fe_raddr(fe_raddr),
    .load_done(load_done), .ld_count(ld_count),
    .mem_enable(mem_enable), .mem_read_writenot(mem_read_writenot),
    .mem_read_address(mem_read_address),
    .mem_write_address(mem_write_address),
    .mem_in_data(mem_in_data), .mem_out_data(mem_out_data)
  );

  always #5 clk = ~clk;

  // memory device driven only by the controller pins
  logic [19:0] env_mem [32];
  initial begin
    for (int i = 0; i < 32; i++) env_mem[i] = 20'hF0000 ^ 20'(i);
    mem_out_data = '0;
  end
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_read_writenot) mem_out_data <= env_mem[mem_read_address];
      else env_mem[mem_write_address] <= mem_in_data;
    end
  end

  // reference model
  bit          m_run;
  int          m_cnt;
  bit          m_last_fe;
  bit          m_pv;
  logic [4:0]  m_pa;
  logic [19:0] m_pd;
  logic [19:0] m_mem [32];
  bit          gl, gf;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_last_fe = 0; m_pv = 0; m_pa = '0;
  endtask

  // one clock: check at negedge, advance model at posedge
  task automatic cycle();
    bit g_ld, g_fe;
    @(negedge clk);
    g_ld = 0; g_fe = 0;
    if (!rst) begin
      if (!m_run) g_ld = ld_valid;
      else begin
`ifdef IMEM_WRITE_LOCK_EN
        g_fe = fe_valid;
`else
        if (ld_valid && fe_valid) g_fe = !m_last_fe;
        else g_fe = fe_valid;
        g_ld = ld_valid && !g_fe;
`endif
      end
    end
    chk("ld_ready", ld_ready, g_ld);
    chk("fe_ready", fe_ready, g_fe);
    chk("mem_enable", mem_enable, g_ld | g_fe);
    chk("mem_rw", mem_read_writenot, !g_ld);
    chk("mem_raddr", mem_read_address, fe_addr);
    chk("mem_wdata", mem_in_data, ld_data);
    chk("fe_rvalid", fe_rvalid, m_pv);
    chk("fe_raddr", fe_raddr, m_pa);
    if (m_pv) chk("fe_rdata", fe_rdata, m_pd);
    chk("load_done", load_done, m_run);
    chk("ld_count", ld_count, m_cnt);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_pv = g_fe;
      if (g_fe) begin m_pa = fe_addr; m_pd = m_mem[fe_addr]; end
      if (g_ld) begin
        m_mem[ld_addr] = ld_data;
        if (!m_run && (ld_last || m_cnt + 1 == 32)) m_run = 1;
        if (m_cnt < 32) m_cnt++;
      end
      if (g_ld || g_fe) m_last_fe = g_fe;
    end
    gl = g_ld; gf = g_fe;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [19:0] d,
                    input logic last);
    int n = 0;
    ld_valid = 1; ld_addr = a; ld_data = d; ld_last = last;
    do begin cycle(); n++; end while (!gl && n < 40);
    if (!gl) chk("ld_wait", 0, 1);
    ld_valid = 0;
  endtask

  task automatic rd(input logic [4:0] a);
    int n = 0;
    fe_valid = 1; fe_addr = a;
    do begin cycle(); n++; end while (!gf && n < 40);
    if (!gf) chk("fe_wait", 0, 1);
    fe_valid = 0;
  endtask

  task automatic run_random(input int n, input int pld, input int pfe);
    for (int i = 0; i < n; i++) begin
      if (!ld_valid && $urandom_range(99) < pld) begin
        ld_valid = 1; ld_addr = 5'($urandom);
        ld_data = 20'($urandom); ld_last = ($urandom_range(7) == 0);
      end
      if (!fe_valid && $urandom_range(99) < pfe) begin
        fe_valid = 1; fe_addr = 5'($urandom);
      end
      cycle();
      if (gl) ld_valid = 0;
      if (gf) fe_valid = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 20'hF0000 ^ 20'(i);
    rst = 1; ld_valid = 1; fe_valid = 1; ld_last = 0;
    ld_addr = '0; ld_data = '0; fe_addr = 5'd1;
    @(posedge clk); #1;
    model_reset();
    cycle(); cycle();
    rst = 0; ld_valid = 0;

    // boot load with fetch held pending the whole time
    wr(5'd0, 20'h00011, 0);
    wr(5'd1, 20'h00022, 0);
    wr(5'd2, 20'h00033, 1);
    #3;
    chk("boot_done", load_done, 1);
    chk("boot_cnt", ld_count, 3);
    rd(5'd1);
    #3;
    chk("rd1_valid", fe_rvalid, 1);
    chk("rd1_addr", fe_raddr, 1);
    chk("rd1_data", fe_rdata, 20'h00022);

    // back-to-back fetches
    fe_valid = 1;
    for (int a = 0; a < 3; a++) begin fe_addr = 5'(a); cycle(); end
    fe_valid = 0;
    cycle();

`ifndef IMEM_WRITE_LOCK_EN
    wr(5'd0, 20'hABCDE, 0);
    rd(5'd0);
    #3;
    chk("wr_rd_data", fe_rdata, 20'hABCDE);
    // sustained contention alternates once both are pending
    ld_valid = 1; fe_valid = 1; ld_addr = 5'd7; fe_addr = 5'd2;
    for (int i = 0; i < 6; i++) begin
      bit prev_fe;
      prev_fe = m_last_fe;
      ld_data = 20'(i);
      cycle();
      chk("alt_grant", gf, !prev_fe);
    end
    ld_valid = 0; fe_valid = 0;
`else
    ld_valid = 1; ld_addr = 5'd3; ld_data = 20'h12345;
    for (int i = 0; i < 10; i++) cycle();
    ld_valid = 0;
`endif

    run_random(150, 50, 60);

    // reset on the cycle after a fetch accept
    ld_valid = 0;
    rd(5'd2);
    rst = 1; fe_valid = 1;
    cycle();
    rst = 0;
    #3;
    chk("rst_rvalid", fe_rvalid, 0);
    chk("rst_done", load_done, 0);
    chk("rst_cnt", ld_count, 0);
    for (int i = 0; i < 3; i++) cycle();

    // saturation boot: 32 writes, no ld_last
    for (int i = 0; i < 32; i++) begin
      wr(5'(i), 20'($urandom), 0);
      if (i == 30) begin #3; chk("sat_not_done", load_done, 0); end
    end
    #3;
    chk("sat_done", load_done, 1);
    chk("sat_cnt", ld_count, 32);
    fe_valid = 0;
    cycle();
`ifndef IMEM_WRITE_LOCK_EN
    wr(5'd5, 20'h55555, 0);
    #3;
    chk("sat_hold", ld_count, 32);
`endif

    run_random(400, 70, 70);
    ld_valid = 0; fe_valid = 0;
    cycle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
